// File: rtl/shiftreg_driver_if.sv
// ---------------------------------------------------------------------------
// shiftreg_driver_if
// Load handshake between the config/register block and shiftreg_driver.
//   load_valid  producer -> driver   tune word available
//   load_ready  driver -> producer   driver idle, word will be taken this edge
//   load_data   producer -> driver   N-bit tune word, bit N-1 shifted first
// Modports: master = config/register side, slave = shiftreg_driver.
// ---------------------------------------------------------------------------
interface shiftreg_driver_if #(
    parameter int N = 59
);
    logic         load_valid;
    logic         load_ready;
    logic [N-1:0] load_data;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/shiftreg_driver.sv
// ---------------------------------------------------------------------------
// shiftreg_driver
// Serial master for the tunable cap array shift chain. Takes an N-bit tune
// word over the load handshake, shifts it MSB-first on sclk/sdin and then
// pulses latch once so the chain updates all tune outputs together.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   load      shiftreg_driver_if.slave (load_valid/load_ready/load_data)
//   sclk      serial clock to chain (chain shifts on rise)
//   sdin      serial data to chain
//   latch     latch strobe (chain captures on rise)
//   sr_out    chain serial output (chain MSB)
//   busy      high from accept until done
//   done      one-cycle pulse on return to IDLE
//   rb_data   previous chain contents (readback build only, else 0)
//   rb_valid  one-cycle pulse with done (readback build only, else 0)
//
// Build option: define CHAIN_READBACK_EN to capture the old chain contents
// from sr_out while the new word is shifted in (needs CLKDIV >= 2).
//
// state       | meaning
// IDLE        | waiting for a word, load_ready=1
// SHIFT_LO    | sclk low, sdin presents current bit
// SHIFT_HI    | sclk high, chain shifts on the rise
// LATCH_SETUP | sclk low, settle before latch
// LATCH_HI    | latch high, chain captures
// LATCH_LO    | latch low hold, then IDLE with done
// ---------------------------------------------------------------------------
module shiftreg_driver #(
    parameter int N      = 59,
    parameter int CLKDIV = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    shiftreg_driver_if.slave     load,
    output logic                 sclk,
    output logic                 sdin,
    output logic                 latch,
    input  logic                 sr_out,
    output logic                 busy,
    output logic                 done,
    output logic [N-1:0]         rb_data,
    output logic                 rb_valid
);
    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] SHIFT_LO    = 3'd1;
    localparam logic [2:0] SHIFT_HI    = 3'd2;
    localparam logic [2:0] LATCH_SETUP = 3'd3;
    localparam logic [2:0] LATCH_HI    = 3'd4;
    localparam logic [2:0] LATCH_LO    = 3'd5;

    localparam int PW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] PHASE_LOAD = PW'(CLKDIV - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(N - 1);

    logic [2:0]    state;
    logic [PW-1:0] phase_cnt;
    logic [BW-1:0] bit_cnt;
    logic [N-1:0]  shadow;
    logic          phase_tc;
    logic          accept;

    assign phase_tc        = (phase_cnt == '0);
    assign load.load_ready = (state == IDLE);
    assign busy            = (state != IDLE);
    assign accept          = load.load_valid && load.load_ready;

    // sclk/sdin/latch are flops updated together with state, so they are
    // glitch-free and always match the state they belong to.
    // The shadow shifts left once per bit, so sdin always comes from its MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            shadow    <= '0;
            sclk      <= 1'b0;
            sdin      <= 1'b0;
            latch     <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && !phase_tc)
                phase_cnt <= phase_cnt - 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shadow    <= load.load_data;
                        sdin      <= load.load_data[N-1];
                        bit_cnt   <= '0;
                        phase_cnt <= PHASE_LOAD;
                        state     <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (phase_tc) begin
                        sclk      <= 1'b1;
                        phase_cnt <= PHASE_LOAD;
                        state     <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (phase_tc) begin
                        sclk      <= 1'b0;
                        phase_cnt <= PHASE_LOAD;
                        if (bit_cnt == BIT_LAST) begin
                            state <= LATCH_SETUP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shadow  <= {shadow[N-2:0], 1'b0};
                            sdin    <= shadow[N-2];
                            state   <= SHIFT_LO;
                        end
                    end
                end
                LATCH_SETUP: begin
                    if (phase_tc) begin
                        latch     <= 1'b1;
                        phase_cnt <= PHASE_LOAD;
                        state     <= LATCH_HI;
                    end
                end
                LATCH_HI: begin
                    if (phase_tc) begin
                        latch     <= 1'b0;
                        phase_cnt <= PHASE_LOAD;
                        state     <= LATCH_LO;
                    end
                end
                LATCH_LO: begin
                    if (phase_tc) begin
                        sdin  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CHAIN_READBACK_EN
    logic [N-1:0] rb_shift;

    // sr_out is sampled just before each sclk rise, so after N bits rb_shift
    // holds the chain contents from before this load, MSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            rb_shift <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (state == SHIFT_LO && phase_tc)
                rb_shift <= {rb_shift[N-2:0], sr_out};
            if (state == LATCH_LO && phase_tc) begin
                rb_data  <= rb_shift;
                rb_valid <= 1'b1;
            end
        end
    end
`else
    logic sr_out_unused;

    assign sr_out_unused = sr_out;
    assign rb_data       = '0;
    assign rb_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_shiftreg_driver.sv
module tb_shiftreg_driver;
    localparam int N = 59;
`ifdef CHAIN_READBACK_EN
    localparam int CLKDIV = 3;
`else
    localparam int CLKDIV = 2;
`endif
    localparam int BUSY_CYC = CLKDIV * (2 * N + 3);
    localparam logic [N-1:0] ALL1 = '1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sclk, sdin, latch, sr_out, busy, done, rb_valid;
    logic [N-1:0] rb_data;

    shiftreg_driver_if #(.N(N)) load_if ();

    shiftreg_driver #(.N(N), .CLKDIV(CLKDIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load_if),
        .sclk     (sclk),
        .sdin     (sdin),
        .latch    (latch),
        .sr_out   (sr_out),
        .busy     (busy),
        .done     (done),
        .rb_data  (rb_data),
        .rb_valid (rb_valid)
    );

    always #5 clk = ~clk;

    // behavioural cap-array chain
    logic [N-1:0] chain_sr  = '0;
    logic [N-1:0] chain_lat = '0;
    assign sr_out = chain_sr[N-1];
    always @(posedge sclk)  chain_sr  <= {chain_sr[N-2:0], sdin};
    always @(posedge latch) chain_lat <= chain_sr;

    // monitors
    int sclk_rises = 0, latch_rises = 0, accepts = 0;
    int busy_run = 0, last_busy_run = 0, done_cnt = 0, rb_cnt = 0;
    int overlap_errs = 0, sdin_errs = 0, done_rdy_errs = 0;
    logic prev_sclk = 1'b0, prev_sdin = 1'b0;

    always @(posedge sclk)  sclk_rises++;
    always @(posedge latch) latch_rises++;
    always @(posedge clk)
        if (!rst && load_if.load_valid && load_if.load_ready) accepts++;

    always @(negedge clk) begin
        if (busy) busy_run++;
        else if (busy_run != 0) begin
            last_busy_run = busy_run;
            busy_run = 0;
        end
        if (done) done_cnt++;
        if (rb_valid) rb_cnt++;
        if (sclk && latch) overlap_errs++;
        if (sclk && prev_sclk && sdin !== prev_sdin) sdin_errs++;
        if (done && !load_if.load_ready) done_rdy_errs++;
        prev_sclk = sclk;
        prev_sdin = sdin;
    end

    int n_checks = 0, n_fail = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // reference: contents of chain shift stage and of latched outputs
    logic [N-1:0] exp_sr  = '0;
    logic [N-1:0] exp_lat = '0;

    task automatic wait_done(output bit ok);
        int t = 0;
        @(negedge clk);
        while (!done && t < BUSY_CYC + 50) begin
            @(negedge clk);
            t++;
        end
        ok = done;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!load_if.load_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic run_and_check(input logic [N-1:0] w, input string tag);
        int  b_s, b_l, b_d, b_r;
        bit  ok;
        logic [N-1:0] prev_sr;
        b_s = sclk_rises; b_l = latch_rises; b_d = done_cnt; b_r = rb_cnt;
        prev_sr = exp_sr;
        wait_ready();
        load_if.load_valid = 1'b1;
        load_if.load_data  = w;
        @(posedge clk);
        #1 load_if.load_valid = 1'b0;
        wait_done(ok);
        check_val({tag, "_done_seen"}, 64'(ok), 64'd1);
        repeat (2) @(negedge clk);
        exp_sr  = w;
        exp_lat = w;
        check_val({tag, "_sclk_rises"}, 64'(sclk_rises - b_s), 64'(N));
        check_val({tag, "_latch_rises"}, 64'(latch_rises - b_l), 64'd1);
        check_val({tag, "_done_pulses"}, 64'(done_cnt - b_d), 64'd1);
        check_val({tag, "_busy_cycles"}, 64'(last_busy_run), 64'(BUSY_CYC));
        check_val({tag, "_latched"}, 64'(chain_lat), 64'(exp_lat));
`ifdef CHAIN_READBACK_EN
        check_val({tag, "_rb_pulses"}, 64'(rb_cnt - b_r), 64'd1);
        check_val({tag, "_rb_data"}, 64'(rb_data), 64'(prev_sr));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        int b_s, b_l, b_a;
        logic [63:0]    r;
        logic [N-1:0]   w, wa, wb;
        logic [2*N-1:0] cat;

        load_if.load_valid = 1'b0;
        load_if.load_data  = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_val("idle_outputs", {58'd0, load_if.load_ready, busy, sclk, sdin, latch, done}, 64'b100000);
        end
        check_val("idle_rb", {rb_data, rb_valid}, 64'd0);

        // directed pattern with field slice
        run_and_check(59'h5A5_A5A5_A5A5_A5A5, "pat5a5");
        check_val("tune_s1_shunt", 64'(chain_lat[7:0]), 64'hA5);

        // back-to-back, valid held high
        b_s = sclk_rises; b_l = latch_rises; b_a = accepts;
        load_if.load_valid = 1'b1;
        load_if.load_data  = 59'h1;
        @(posedge clk);
        #1 load_if.load_data = ALL1;
        wait_done(ok);
        check_val("b2b_first_done", 64'(ok), 64'd1);
        check_val("b2b_ready_on_done", 64'(load_if.load_ready), 64'd1);
        @(posedge clk);
        #1 load_if.load_valid = 1'b0;
        @(negedge clk);
        check_val("b2b_no_gap_busy", 64'(busy), 64'd1);
        check_val("b2b_first_latched", 64'(chain_lat), 64'h1);
        wait_done(ok);
        check_val("b2b_second_done", 64'(ok), 64'd1);
        repeat (2) @(negedge clk);
        check_val("b2b_accepts", 64'(accepts - b_a), 64'd2);
        check_val("b2b_sclk_rises", 64'(sclk_rises - b_s), 64'(2 * N));
        check_val("b2b_latch_rises", 64'(latch_rises - b_l), 64'd2);
        check_val("b2b_busy_cycles", 64'(last_busy_run), 64'(BUSY_CYC));
        check_val("b2b_latched", 64'(chain_lat), 64'(ALL1));
`ifdef CHAIN_READBACK_EN
        check_val("b2b_rb_data", 64'(rb_data), 64'h1);
`endif
        exp_sr = ALL1; exp_lat = ALL1;

        // load_valid during busy is ignored
        r = {$urandom(), $urandom()}; wa = r[N-1:0];
        wb = ~wa;
        b_a = accepts;
        load_if.load_valid = 1'b1;
        load_if.load_data  = wa;
        @(posedge clk);
        #1 load_if.load_valid = 1'b0;
        repeat (50) @(negedge clk);
        load_if.load_valid = 1'b1;
        load_if.load_data  = wb;
        repeat (20) @(negedge clk);
        load_if.load_valid = 1'b0;
        wait_done(ok);
        check_val("ignore_done", 64'(ok), 64'd1);
        repeat (2) @(negedge clk);
        check_val("ignore_accepts", 64'(accepts - b_a), 64'd1);
        check_val("ignore_latched", 64'(chain_lat), 64'(wa));
        exp_sr = wa; exp_lat = wa;

        // reset in the middle of a shift
        r = {$urandom(), $urandom()}; w = r[N-1:0];
        b_s = sclk_rises; b_l = latch_rises;
        load_if.load_valid = 1'b1;
        load_if.load_data  = w;
        @(posedge clk);
        #1 load_if.load_valid = 1'b0;
        for (int t = 0; t < BUSY_CYC && (sclk_rises - b_s) < 30; t++) @(negedge clk);
        check_val("abort_reached_bit30", 64'(sclk_rises - b_s), 64'd30);
        rst = 1'b1;
        @(posedge clk);
        #1 check_val("abort_outputs", {58'd0, load_if.load_ready, busy, sclk, sdin, latch, done}, 64'b100000);
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * BUSY_CYC) @(negedge clk);
        check_val("abort_sclk_rises", 64'(sclk_rises - b_s), 64'd30);
        check_val("abort_latch_rises", 64'(latch_rises - b_l), 64'd0);
        check_val("abort_latched_kept", 64'(chain_lat), 64'(exp_lat));
        cat = {exp_sr, w};
        exp_sr = cat[2*N-1-30 -: N];
        run_and_check(w ^ 59'h2AA, "after_abort");

        // random words
        for (int i = 0; i < 4; i++) begin
            r = {$urandom(), $urandom()};
            run_and_check(r[N-1:0], $sformatf("rand%0d", i));
        end

`ifdef CHAIN_READBACK_EN
        run_and_check(59'h123_4567_89AB_CDEF, "rb_first");
        run_and_check(59'h123_4567_89AB_CDEF, "rb_second");
        check_val("rb_integrity", 64'(rb_data), 64'h123_4567_89AB_CDEF);
`endif

        check_val("sclk_latch_overlap", 64'(overlap_errs), 64'd0);
        check_val("sdin_change_sclk_hi", 64'(sdin_errs), 64'd0);
        check_val("done_without_ready", 64'(done_rdy_errs), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
